alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Parametrised, multi-cycle successor to the processor's single-cycle ALU.
- Executes the existing base integer ops with one registered cycle of latency.
- Adds the RV32M multiply/divide/remainder ops using an iterative shift-add multiplier and a restoring divider.
- Sits in the execute stage behind a valid/ready handshake, so the control unit can stall on long ops.

Parameters:
XLEN, 32, operand and result width in bits (power of two, >= 8)
SHW, $clog2(XLEN), shift-amount width (derived; do not override)

Ports:
clk        input   1      clock, rising edge
rst        input   1      asynchronous, active-high reset
flush      input   1      synchronous abort of any in-flight op
in_valid   input   1      operands and op presented
in_ready   output  1      block can accept a new op
op         input   5      operation code (alu_pkg::alu_op_e)
a          input   XLEN   operand A
b          input   XLEN   operand B
out_valid  output  1      result valid
out_ready  input   1      consumer accepts result
result     output  XLEN   result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, all internal accumulators=0.
- Handshake:
  - An op is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE).
  - A result is consumed when out_valid && out_ready.
  - result is held stable while out_valid && !out_ready.
- Op encoding, base group (op[4]=0): ADD 00000, SUB 01000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111, PASSB 01001.
- Op encoding, M group (op[4]=1): MUL 10000, MULH 10001, MULHSU 10010, MULHU 10011, DIV 10100, DIVU 10101, REM 10110, REMU 10111.
- Any other code yields result 0 with base latency. The block never latches.
- Shift rule: shifts use b[SHW-1:0] only. SRA is arithmetic on a signed a.
- Compare rules: SLT is a signed compare; SLTU is an unsigned compare. The result is zero-extended 0/1.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN.
- States:
  - IDLE: on accept of a base op -> DONE. On accept of MUL* -> MUL. On accept of DIV*/REM* -> DIV, except the special cases below.
  - MUL: XLEN iterations, one partial product bit per cycle, on a 2*XLEN accumulator.
  - DIV: XLEN iterations, one quotient bit per cycle, restoring.
  - DONE: out_valid=1. On out_ready -> IDLE.
- Multiply:
  - Operands are converted to magnitudes per op signedness: MULH is s*s, MULHSU is s*u, MULHU is u*u.
  - The product is negated at the end if the sign flag is set.
  - MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide:
  - Operands are converted to magnitudes for DIV/REM.
  - Quotient sign is sign(a)^sign(b). Remainder sign is sign(a).
- Divide special cases (no iteration, take the base latency path):
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow, a=-2^(XLEN-1) and b=-1: quotient = a; remainder = 0.
- Latency, accept to out_valid:
  - Base ops and divide special cases: 1 cycle.
  - Normal mul/div: XLEN+1 cycles. Iteration counter 0..XLEN-1, then one fix-up cycle that loads result.
  - Each latency has no additional wait states.
- Back-to-back: a new op is accepted only in IDLE. Minimum throughput is one base op per 2 cycles. in_ready must not go high combinationally from out_ready.
- flush: in any state, the next edge goes to IDLE with out_valid=0. The counter is cleared and result is cleared to 0. flush wins over a simultaneous accept or consume.
- Reset mid-operation: immediate abort to the reset values. No partial result is ever presented.
- Operands are captured at accept. Changes on a/b/op afterwards have no effect.

Decomposition:
- alu_pkg holds:
  - alu_op_e: 5-bit enum of the codes above.
  - state_e: IDLE, MUL, DIV, DONE.
  - helper function is_signed_a/is_signed_b(op).
  - default XLEN constant.
- One sub-module, muldiv_iter, contains the iteration datapath: accumulator, counter, and magnitude/sign fix-up.
  - Interface: start, mode, a_mag, b_mag, neg_flags, busy, done, hi, lo.
  - The top level owns the FSM, the handshake, the base-op combinational logic, and the special-case detection.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000 one cycle after accept. SRA a=0x80000000, b=0x21 (shamt 1) -> 0xC0000000. Undefined op 0x1F -> 0.
- MULH a=-2 (0xFFFFFFFE), b=3 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFF. MUL on the same operands -> 0xFFFFFFFA. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIV a=-7, b=2 -> quotient 0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2. All take 33-cycle latency.
- DIVU a=5, b=0 -> 0xFFFFFFFF in 1 cycle. REM a=5, b=0 -> 5. DIV a=0x80000000, b=-1 -> 0x80000000. REM on the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after a MUL completes -> result stable, in_ready=0. Raise out_ready -> next cycle IDLE, in_ready=1.
- Assert rst in cycle 10 of a DIV -> out_valid=0 immediately. flush in cycle 5 of a MUL -> IDLE on the next edge. A follow-up ADD 2+2 -> 4 with correct 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU with RV32M multiply/divide.
//   alu_op_e      : 5-bit operation codes (op[4]=0 base group, op[4]=1 M group)
//   state_e       : top-level control states
//   is_signed_a/b : operand signedness per M-group op
//   XLEN_DEFAULT  : default datapath width
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [4:0] {
      OP_ADD    = 5'b00000,
      OP_SLL    = 5'b00001,
      OP_SLT    = 5'b00010,
      OP_SLTU   = 5'b00011,
      OP_XOR    = 5'b00100,
      OP_SRL    = 5'b00101,
      OP_OR     = 5'b00110,
      OP_AND    = 5'b00111,
      OP_SUB    = 5'b01000,
      OP_PASSB  = 5'b01001,
      OP_SRA    = 5'b01101,
      OP_MUL    = 5'b10000,
      OP_MULH   = 5'b10001,
      OP_MULHSU = 5'b10010,
      OP_MULHU  = 5'b10011,
      OP_DIV    = 5'b10100,
      OP_DIVU   = 5'b10101,
      OP_REM    = 5'b10110,
      OP_REMU   = 5'b10111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic is_signed_a(input logic [4:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [4:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine with sign fix-up.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : abort any iteration in progress
//   start       : load magnitudes and begin (first step happens on this edge)
//   mode        : 0 = shift-add multiply, 1 = restoring divide
//   a_mag,b_mag : operand magnitudes (multiplier/multiplicand or dividend/divisor)
//   neg_flags   : [0] negate product / quotient, [1] negate remainder
//   busy        : iterating or presenting the fix-up result
//   done        : hi/lo carry the final signed result this cycle
//   hi, lo      : multiply: product high/low half; divide: remainder/quotient
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
   input  logic            mode,
   input  logic [XLEN-1:0] a_mag,
   input  logic [XLEN-1:0] b_mag,
   input  logic [1:0]      neg_flags,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int SHW = $clog2(XLEN);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   m;
   logic [SHW-1:0]    cnt;
   logic              mode_q;
   logic [1:0]        neg_q;
   logic              run;
   logic              fix;
   logic [2*XLEN-1:0] prod;

   // One step. Multiply: acc = {partial_hi, multiplier}, add multiplicand on
   // the LSB and shift right. Divide: acc = {remainder, dividend/quotient},
   // shift left and restore-subtract the divisor.
   function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] acc_i,
                                              input logic [XLEN-1:0]   m_i,
                                              input logic              div_i);
      logic [XLEN:0] sum;
      logic [XLEN:0] shifted;
      if (!div_i) begin
         sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, m_i} : {(XLEN+1){1'b0}});
         return {sum, acc_i[XLEN-1:1]};
      end
      shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      if (shifted >= {1'b0, m_i}) begin
         sum = shifted - {1'b0, m_i};
         return {sum[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
      return {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
   endfunction

   assign busy = run | fix;
   assign done = fix;

   // cnt counts completed steps; the start edge already performs step one,
   // so XLEN steps finish on the (XLEN-1)th edge after start and the
   // following cycle is the fix-up cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         m      <= '0;
         cnt    <= '0;
         mode_q <= 1'b0;
         neg_q  <= '0;
         run    <= 1'b0;
         fix    <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
         run <= 1'b0;
         fix <= 1'b0;
      end else if (start) begin
         acc    <= step({{XLEN{1'b0}}, a_mag}, b_mag, mode);
         m      <= b_mag;
         mode_q <= mode;
         neg_q  <= neg_flags;
         cnt    <= SHW'(1);
         run    <= 1'b1;
         fix    <= 1'b0;
      end else if (run) begin
         acc <= step(acc, m, mode_q);
         if (cnt == SHW'(XLEN-1)) begin
            cnt <= '0;
            run <= 1'b0;
            fix <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (fix) begin
         fix <= 1'b0;
      end
   end

   // Sign fix-up: the whole 2*XLEN product is negated as one value, while
   // quotient and remainder carry independent signs.
   always_comb begin
      prod = neg_q[0] ? -acc : acc;
      if (!mode_q) begin
         hi = prod[2*XLEN-1:XLEN];
         lo = prod[XLEN-1:0];
      end else begin
         lo = neg_q[0] ? -acc[XLEN-1:0] : acc[XLEN-1:0];
         hi = neg_q[1] ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle execute-stage ALU: base integer ops in one registered cycle,
// RV32M multiply/divide/remainder through an iterative engine.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : synchronous abort to IDLE, clears result
//   in_valid, in_ready  : op/operand handshake (ready only in IDLE)
//   op, a, b            : operation code and operands, captured at accept
//   out_valid, out_ready: result handshake, result stable while stalled
//   result              : XLEN-bit result
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state, state_nxt;
   alu_op_e         op_q;
   logic            accept;
   logic            is_md, is_div, is_rem;
   logic            b_zero, div_ovf, special;
   logic            sign_a, sign_b;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [1:0]      neg_flags;
   logic [XLEN-1:0] base_res, spec_res, md_res;
   logic            iter_start, iter_busy, iter_done;
   logic [XLEN-1:0] iter_hi, iter_lo;

   function automatic logic [XLEN-1:0] base_op(input logic [4:0]      op_i,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
      logic signed [XLEN-1:0] xs;
      logic signed [XLEN-1:0] ys;
      logic [SHW-1:0]         shamt;
      xs    = x;
      ys    = y;
      shamt = y[SHW-1:0];
      case (op_i)
         OP_ADD:   return x + y;
         OP_SUB:   return x - y;
         OP_SLL:   return x << shamt;
         OP_SLT:   return {{(XLEN-1){1'b0}}, (xs < ys)};
         OP_SLTU:  return {{(XLEN-1){1'b0}}, (x < y)};
         OP_XOR:   return x ^ y;
         OP_SRL:   return x >> shamt;
         OP_SRA:   return xs >>> shamt;
         OP_OR:    return x | y;
         OP_AND:   return x & y;
         OP_PASSB: return y;
         default:  return '0;
      endcase
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      accept    = in_valid && in_ready && !flush;
      is_md     = (op[4:3] == 2'b10);
      is_div    = is_md && op[2];
      is_rem    = op[1];
      b_zero    = (b == '0);
      div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
      special   = is_div && (b_zero || div_ovf);
      sign_a    = is_signed_a(op) && a[XLEN-1];
      sign_b    = is_signed_b(op) && b[XLEN-1];
      a_mag     = sign_a ? -a : a;
      b_mag     = sign_b ? -b : b;
      // Divide: quotient sign is sign(a)^sign(b), remainder follows a.
      neg_flags = {is_div && sign_a, sign_a ^ sign_b};
      base_res  = base_op(op, a, b);
      if (b_zero) spec_res = is_rem ? a : '1;
      else        spec_res = is_rem ? '0 : a;
      iter_start = accept && is_md && !special;
      case (op_q)
         OP_MUL, OP_DIV, OP_DIVU: md_res = iter_lo;
         default:                 md_res = iter_hi;
      endcase
   end

   muldiv_iter #(
      .XLEN(XLEN)
   ) u_iter (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .start    (iter_start),
      .mode     (is_div),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .neg_flags(neg_flags),
      .busy     (iter_busy),
      .done     (iter_done),
      .hi       (iter_hi),
      .lo       (iter_lo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_md && !special) state_nxt = is_div ? DIV : MUL;
                  else                   state_nxt = DONE;
               end
            end
            MUL, DIV: begin
               if (iter_done)       state_nxt = DONE;
               else if (!iter_busy) state_nxt = IDLE;
            end
            DONE: begin
               if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         op_q   <= OP_ADD;
      end else if (flush) begin
         result <= '0;
      end else if (accept) begin
         op_q <= alu_op_e'(op);
         if (!is_md)       result <= base_res;
         else if (special) result <= spec_res;
      end else if (((state == MUL) || (state == DIV)) && iter_done) begin
         result <= md_res;
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [4:0]  o;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
      logic [7:0]  lat;
   } vec_t;

   logic [4:0] codes [0:18] = '{5'h00, 5'h08, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                                5'h0D, 5'h06, 5'h07, 5'h09, 5'h10, 5'h11, 5'h12,
                                5'h13, 5'h14, 5'h15, 5'h16, 5'h17};

   alu_muldiv_seq #(.XLEN(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Reference model: RISC-V semantics computed with 64-bit integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
      longint sx, sy, ux, uy;
      logic [63:0] p;
      int sh;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      sh = int'(y[4:0]);
      case (o)
         5'b00000: return x + y;
         5'b01000: return x - y;
         5'b00001: return x << sh;
         5'b00010: return {31'b0, sx < sy};
         5'b00011: return {31'b0, ux < uy};
         5'b00100: return x ^ y;
         5'b00101: return x >> sh;
         5'b01101: begin p = sx >>> sh; return p[31:0]; end
         5'b00110: return x | y;
         5'b00111: return x & y;
         5'b01001: return y;
         5'b10000: begin p = sx * sy; return p[31:0]; end
         5'b10001: begin p = sx * sy; return p[63:32]; end
         5'b10010: begin p = sx * uy; return p[63:32]; end
         5'b10011: begin p = ux * uy; return p[63:32]; end
         5'b10100: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            p = sx / sy; return p[31:0];
         end
         5'b10101: begin
            if (y == 0) return 32'hFFFF_FFFF;
            p = ux / uy; return p[31:0];
         end
         5'b10110: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
            p = sx % sy; return p[31:0];
         end
         5'b10111: begin
            if (y == 0) return x;
            p = ux % uy; return p[31:0];
         end
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [4:0] o, input logic [31:0] x,
                                      input logic [31:0] y);
      if (o < 5'h10 || o > 5'h17) return 1;
      if (o >= 5'h14 && y == 0) return 1;
      if ((o == 5'h14 || o == 5'h16) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Presents one op at a falling edge, scrambles the inputs right after the
   // accept edge, and counts edges (accept edge = 1) until out_valid.
   task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit consume, output logic [31:0] res, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op = 5'($urandom); a = $urandom; b = $urandom;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      res = result;
      if (consume) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 5'h0; a = 32'h0; b = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", in_ready); end
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got=%b want=0", out_valid); end
      total++;
      if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got=%h want=0", result); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      vec_t vecs[$];
      logic [31:0] res;
      int lat;
      vecs.push_back('{5'h00, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 8'd1});
      vecs.push_back('{5'h0D, 32'h8000_0000, 32'h21,        32'hC000_0000, 8'd1});
      vecs.push_back('{5'h1F, 32'h1234_5678, 32'h9,         32'h0,         8'd1});
      vecs.push_back('{5'h08, 32'h0,         32'h1,         32'hFFFF_FFFF, 8'd1});
      vecs.push_back('{5'h02, 32'hFFFF_FFFF, 32'h1,         32'h1,         8'd1});
      vecs.push_back('{5'h03, 32'hFFFF_FFFF, 32'h1,         32'h0,         8'd1});
      vecs.push_back('{5'h01, 32'h1,         32'h3F,        32'h8000_0000, 8'd1});
      vecs.push_back('{5'h09, 32'h5,         32'hABCD_0123, 32'hABCD_0123, 8'd1});
      vecs.push_back('{5'h11, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 8'd33});
      vecs.push_back('{5'h10, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFA, 8'd33});
      vecs.push_back('{5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33});
      vecs.push_back('{5'h14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 8'd33});
      vecs.push_back('{5'h16, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 8'd33});
      vecs.push_back('{5'h15, 32'd100,       32'd7,         32'd14,        8'd33});
      vecs.push_back('{5'h17, 32'd100,       32'd7,         32'd2,         8'd33});
      vecs.push_back('{5'h15, 32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1});
      vecs.push_back('{5'h16, 32'd5,         32'd0,         32'd5,         8'd1});
      vecs.push_back('{5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1});
      vecs.push_back('{5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         8'd1});
      foreach (vecs[i]) begin
         run_op(vecs[i].o, vecs[i].x, vecs[i].y, 1'b1, res, lat);
         total++;
         if (res !== vecs[i].exp) begin
            bad++;
            $display("FAIL directed_result[%0d] op=%h: got=%h want=%h", i, vecs[i].o, res, vecs[i].exp);
         end
         total++;
         if (lat != int'(vecs[i].lat)) begin
            bad++;
            $display("FAIL directed_latency[%0d] op=%h: got=%0d want=%0d", i, vecs[i].o, lat, vecs[i].lat);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0]  o;
      logic [31:0] x, y, res;
      int lat;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 15) == 0) o = 5'($urandom);
         else                            o = codes[$urandom_range(0, 18)];
         x = pick_operand();
         y = pick_operand();
         run_op(o, x, y, 1'b1, res, lat);
         total++;
         if (res !== ref_result(o, x, y)) begin
            bad++;
            $display("FAIL random_result op=%h a=%h b=%h: got=%h want=%h", o, x, y, res, ref_result(o, x, y));
         end
         total++;
         if (lat != ref_latency(o, x, y)) begin
            bad++;
            $display("FAIL random_latency op=%h a=%h b=%h: got=%0d want=%0d", o, x, y, lat, ref_latency(o, x, y));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] res, x, y, exp;
      int lat;
      x = $urandom; y = $urandom;
      exp = ref_result(5'h10, x, y);
      out_ready = 1'b0;
      run_op(5'h10, x, y, 1'b0, res, lat);
      total++;
      if (res !== exp) begin bad++; $display("FAIL bp_result: got=%h want=%h", res, exp); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         total++;
         if (result !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold[%0d]: result=%h out_valid=%b in_ready=%b want %h/1/0",
                     i, result, out_valid, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_comb: got=%b want=0", in_ready); end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] res, x, y;
      int lat;
      op = 5'h14; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_busy: in_ready=%b want=0", in_ready); end
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         bad++;
         $display("FAIL mid_reset: out_valid=%b in_ready=%b result=%h want 0/1/0", out_valid, in_ready, result);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      x = $urandom; y = $urandom_range(1, 1000);
      run_op(5'h16, x, y, 1'b1, res, lat);
      total++;
      if (res !== ref_result(5'h16, x, y) || lat != 33) begin
         bad++;
         $display("FAIL post_reset_rem: got=%h lat=%0d want=%h lat=33", res, lat, ref_result(5'h16, x, y));
      end
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int lat;
      int seen;
      op = 5'h10; a = 32'd12345; b = 32'd678; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
         bad++;
         $display("FAIL flush_mul: in_ready=%b out_valid=%b result=%h want 1/0/0", in_ready, out_valid, result);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL flush_stray_valid: got=%0d cycles want=0", seen); end
      run_op(5'h00, 32'd2, 32'd2, 1'b1, res, lat);
      total++;
      if (res !== 32'd4 || lat != 1) begin
         bad++;
         $display("FAIL flush_followup_add: got=%h lat=%0d want=4 lat=1", res, lat);
      end
      // flush while a result waits and the consumer is ready
      run_op(5'h00, 32'd5, 32'd6, 1'b0, res, lat);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_done: out_valid=%b result=%h in_ready=%b want 0/0/1", out_valid, result, in_ready);
      end
      // flush beats a simultaneous accept
      op = 5'h00; a = 32'd7; b = 32'd8; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         bad++;
         $display("FAIL flush_vs_accept: out_valid=%b in_ready=%b result=%h want 0/1/0", out_valid, in_ready, result);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  o;
      logic [31:0] x, y, res;
      int lat;
      int start_cyc;
      int errs;
      errs = 0;
      start_cyc = cyc;
      for (int i = 0; i < 8; i++) begin
         o = codes[$urandom_range(0, 10)];
         x = $urandom; y = $urandom;
         run_op(o, x, y, 1'b1, res, lat);
         if (res !== ref_result(o, x, y)) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL b2b_results: got=%0d wrong want=0", errs); end
      total++;
      if (cyc - start_cyc != 16) begin
         bad++;
         $display("FAIL b2b_throughput: got=%0d cycles want=16", cyc - start_cyc);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_flush();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
